// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative RV32M multiplier.
// Operation codes follow funct3[1:0] of the M extension.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_code_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_t;

  function automatic logic is_signed_a(mul_code_t c);
    return (c == MULH) || (c == MULHSU);
  endfunction

  function automatic logic is_signed_b(mul_code_t c);
    return c == MULH;
  endfunction

endpackage

// File: rtl/mul_step_unit.sv
// One shift-add iteration: adds |a| times a STEP_BITS slice of
// the multiplier, aligned to bit position pos, into the accumulator.
module mul_step_unit
  import mul_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 2,
  parameter int AW        = 2 * DATA_W + STEP_BITS,
  parameter int SW        = $clog2(DATA_W)
) (
  input  logic [AW-1:0]        acc,
  input  logic [DATA_W-1:0]    mcand,
  input  logic [STEP_BITS-1:0] mbits,
  input  logic [SW-1:0]        pos,
  output logic [AW-1:0]        acc_nxt
);

  localparam int PW = DATA_W + STEP_BITS;

  logic [PW-1:0] pp;
  logic [AW-1:0] pp_al;

  always_comb begin
    pp      = {{STEP_BITS{1'b0}}, mcand}
            * {{DATA_W{1'b0}}, mbits};
    pp_al   = AW'(pp) << pos;
    acc_nxt = acc + pp_al;
  end

endmodule

// File: rtl/mul_iter_r32m.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a
// valid/ready front end, flush support and zero early-out.
module mul_iter_r32m
  import mul_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mul_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int N  = DATA_W / STEP_BITS;
  localparam int AW = 2 * DATA_W + STEP_BITS;
  localparam int SW = $clog2(DATA_W);
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * DATA_W;

  mul_state_t        state;
  mul_code_t         code;
  mul_code_t         req;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     pos;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_nxt;
  logic [PW-1:0]     prod;
  logic              accept;
  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic              unused_acc_hi;

  assign in_ready = (state == IDLE)
                 || (state == DONE && out_ready);
  assign busy     = state != IDLE;
  assign accept   = in_valid && in_ready && !flush;

  assign req   = mul_code_t'(mul_code);
  assign sa    = is_signed_a(req) && op_a[DATA_W-1];
  assign sb    = is_signed_b(req) && op_b[DATA_W-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;

  // The guard bits above 2*DATA_W never carry a final value.
  assign unused_acc_hi = ^acc[AW-1:PW];
  assign prod = (a_neg ^ b_neg) ? -acc[PW-1:0]
                                : acc[PW-1:0];

  mul_step_unit #(
    .DATA_W   (DATA_W),
    .STEP_BITS(STEP_BITS)
  ) u_step (
    .acc    (acc),
    .mcand  (mcand),
    .mbits  (mplier[STEP_BITS-1:0]),
    .pos    (pos),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      code      <= MUL;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      pos       <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            code   <= req;
            a_neg  <= sa;
            b_neg  <= sb;
            mcand  <= mag_a;
            mplier <= mag_b;
            cnt    <= CW'(N);
            pos    <= '0;
            acc    <= '0;
            if (op_a == '0 || op_b == '0) begin
              state     <= DONE;
              result    <= '0;
              out_valid <= 1'b1;
            end else begin
              state     <= CALC;
              out_valid <= 1'b0;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier >> STEP_BITS;
          cnt    <= cnt - 1'b1;
          pos    <= pos + SW'(STEP_BITS);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          result    <= (code == MUL) ? prod[DATA_W-1:0]
                                     : prod[PW-1:DATA_W];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
